// File: rtl/ram_access_controller.sv
// rtl/ram_access_controller.sv - initiator-side controller for the banked synchronous single-port RAM
//
// Accepts single or burst read/write requests over valid/ready handshakes and
// sequences the RAM pins. Every write beat takes at least two cycles: one to
// accept the word, one to drive it. Every read beat takes at least three cycles:
// address, capture, then a hold cycle. The hold cycle lasts until the consumer
// takes the beat. All RAM controls decode from the state register alone.
//
// Ports:
//   clk, rst              clock (rising edge) and synchronous active-high reset
//   req_valid/req_ready   request handshake; req_write, req_addr, req_len (beats-1)
//   wr_valid/wr_ready     write beat handshake; wr_data
//   rd_valid/rd_ready     read beat handshake; rd_data, rd_last
//   busy                  high whenever a burst is in progress
//   addr, data            RAM address and tri-state data bus
//   chip_select, write_enable, output_enable   RAM strobes
module ram_access_controller #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data,
  output logic                  chip_select,
  output logic                  write_enable,
  output logic                  output_enable
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ACCEPT,
    S_WR_DRIVE,
    S_RD_ADDR,
    S_RD_CAP,
    S_RD_HOLD
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [DATA_WIDTH-1:0] wr_word;
  logic                  drive_data;
  logic                  last_beat;

  assign last_beat = (remaining == '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control decode. The RAM strobes depend on the state only.
  // This keeps them free of any combinational path from the handshake inputs.
  always_comb begin
    state_next    = state;
    req_ready     = 1'b0;
    wr_ready      = 1'b0;
    chip_select   = 1'b0;
    write_enable  = 1'b0;
    output_enable = 1'b0;
    drive_data    = 1'b0;
    case (state)
      S_IDLE: begin
        // Masked by rst so that a request offered during reset is not claimed
        req_ready = ~rst;
        if (req_valid) begin
          state_next = req_write ? S_WR_ACCEPT : S_RD_ADDR;
        end
      end
      S_WR_ACCEPT: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          state_next = S_WR_DRIVE;
        end
      end
      S_WR_DRIVE: begin
        chip_select  = 1'b1;
        write_enable = 1'b1;
        drive_data   = 1'b1;
        state_next   = last_beat ? S_IDLE : S_WR_ACCEPT;
      end
      S_RD_ADDR: begin
        chip_select   = 1'b1;
        output_enable = 1'b1;
        state_next    = S_RD_CAP;
      end
      S_RD_CAP: begin
        chip_select   = 1'b1;
        output_enable = 1'b1;
        state_next    = S_RD_HOLD;
      end
      S_RD_HOLD: begin
        if (rd_ready) begin
          state_next = rd_last ? S_IDLE : S_RD_ADDR;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Burst bookkeeping and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr  <= '0;
      remaining <= '0;
      wr_word   <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_last   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            cur_addr  <= req_addr;
            remaining <= req_len;
          end
        end
        S_WR_ACCEPT: begin
          if (wr_valid) begin
            wr_word <= wr_data;
          end
        end
        S_WR_DRIVE: begin
          if (!last_beat) begin
            cur_addr  <= cur_addr + ADDR_WIDTH'(1);
            remaining <= remaining - LEN_WIDTH'(1);
          end
        end
        S_RD_CAP: begin
          // The RAM presents the word latched at the end of the address cycle
          rd_data  <= data;
          rd_valid <= 1'b1;
          rd_last  <= last_beat;
        end
        S_RD_HOLD: begin
          if (rd_ready) begin
            rd_valid <= 1'b0;
            if (!rd_last) begin
              cur_addr  <= cur_addr + ADDR_WIDTH'(1);
              remaining <= remaining - LEN_WIDTH'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign addr = cur_addr;
  // Only the write-drive state owns the bus, and output_enable is 0 there
  assign data = drive_data ? wr_word : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_ram_access_controller.sv
// tb/tb_ram_access_controller.sv - randomized and directed self-checking bench for ram_access_controller
`timescale 1ns/1ps
module tb_ram_access_controller;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [LW-1:0] req_len = '0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_ready = 1'b0;
  logic          req_ready, wr_ready, rd_valid, rd_last, busy;
  logic          chip_select, write_enable, output_enable;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] addr;
  wire  [DW-1:0] data;

  ram_access_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy), .addr(addr), .data(data),
    .chip_select(chip_select), .write_enable(write_enable), .output_enable(output_enable)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: writes at the closing edge, read word latched at the edge, presented while oe
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] ram_q = '0;
  always @(posedge clk) begin
    if (chip_select && write_enable) ram[addr] <= data;
    if (chip_select && output_enable) ram_q <= ram[addr];
  end
  assign data = (chip_select && output_enable) ? ram_q : {DW{1'bz}};

  // Reference model: memory contents plus expected write/read beat streams
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_exp_t;
  typedef struct { logic [DW-1:0] d; logic last; logic first; } rd_exp_t;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  wr_exp_t       exp_wr [$];
  rd_exp_t       exp_rd [$];
  logic [DW-1:0] wq [$];
  logic [AW-1:0] wr_log [$];
  logic [DW-1:0] got_rd [$];
  logic          got_last [$];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_hs_cyc = 0;
  bit tie_mode = 1'b0;
  bit rd_rand = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model and the bus rules
  logic          prev_rdv = 0, prev_rdr = 0, prev_last = 0, prev_hs = 0;
  logic [DW-1:0] prev_rdd = '0;
  logic [AW-1:0] prev_addr = '0;
  always @(negedge clk) begin
    wr_exp_t e;
    rd_exp_t r;
    logic hs;
    cyc++;
    if (!rst) begin
      chk("we_and_oe", 32'(write_enable & output_enable), 0);
      chk("req_ready_vs_busy", 32'(req_ready), 32'(!busy));
      if (chip_select && write_enable) begin
        chk("write_expected", 32'(exp_wr.size() != 0), 1);
        if (exp_wr.size() != 0) begin
          e = exp_wr.pop_front();
          chk("write_addr", 32'(addr), 32'(e.a));
          chk("write_data", 32'(data), 32'(e.d));
          wr_log.push_back(addr);
        end
      end
      if (chip_select && output_enable) chk("read_expected", 32'(exp_rd.size() != 0), 1);
      if (chip_select) chk("rd_valid_during_access", 32'(rd_valid), 0);
      if (prev_rdv && !prev_rdr) begin
        chk("hold_valid", 32'(rd_valid), 1);
        chk("hold_data", 32'(rd_data), 32'(prev_rdd));
        chk("hold_last", 32'(rd_last), 32'(prev_last));
        chk("hold_addr", 32'(addr), 32'(prev_addr));
        chk("hold_cs", 32'(chip_select), 0);
      end
      if (prev_hs && !prev_last) begin
        chk("next_beat_start", 32'(chip_select && output_enable), 1);
        chk("next_beat_addr", 32'(addr), 32'(AW'(prev_addr + 1)));
      end
      hs = rd_valid && rd_ready;
      if (hs) begin
        chk("read_beat_expected", 32'(exp_rd.size() != 0), 1);
        if (exp_rd.size() != 0) begin
          r = exp_rd.pop_front();
          chk("read_data", 32'(rd_data), 32'(r.d));
          chk("read_last", 32'(rd_last), 32'(r.last));
          if (tie_mode && !r.first) chk("beat_period", 32'(cyc - last_hs_cyc), 3);
        end
        last_hs_cyc = cyc;
        got_rd.push_back(rd_data);
        got_last.push_back(rd_last);
      end
      prev_rdv  = rd_valid;
      prev_rdr  = rd_ready;
      prev_rdd  = rd_data;
      prev_last = rd_last;
      prev_addr = addr;
      prev_hs   = hs;
    end else begin
      prev_rdv = 0;
      prev_hs  = 0;
    end
  end

  // Random consumer backpressure
  initial forever begin
    @(posedge clk);
    #1;
    if (rd_rand) rd_ready = ($urandom_range(0, 2) != 0);
  end

  task automatic issue(input logic w, input logic [AW-1:0] a, input int l);
    int n;
    req_valid = 1'b1; req_write = w; req_addr = a; req_len = LW'(l);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_timeout", 32'(req_ready), 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Waits for the burst to finish; optionally offers bogus requests while busy
  task automatic wait_idle(input bit spam);
    bit to;
    to = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (!busy) begin
        req_valid = 1'b0;
        to = 1'b0;
        break;
      end
      if (spam) begin
        req_valid = 1'b1;
        req_write = 1'($urandom);
        req_addr = AW'($urandom);
        req_len = LW'($urandom);
      end
    end
    chk("idle_timeout", 32'(to), 0);
  endtask

  task automatic write_burst(input logic [AW-1:0] a, input int l, input int gap);
    logic [DW-1:0] d [$];
    for (int i = 0; i <= l; i++) begin
      d.push_back((wq.size() != 0) ? wq.pop_front() : DW'($urandom));
      exp_wr.push_back('{AW'(a + i), d[i]});
      ref_mem[AW'(a + i)] = d[i];
    end
    issue(1'b1, a, l);
    for (int i = 0; i <= l; i++) begin
      int g;
      bit to;
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      repeat (g) @(posedge clk);
      #1;
      wr_valid = 1'b1;
      wr_data = d[i];
      to = 1'b1;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (wr_ready) begin
          to = 1'b0;
          break;
        end
      end
      chk("wr_ready_timeout", 32'(to), 0);
      @(posedge clk);
      #1 wr_valid = 1'b0;
    end
    wait_idle(1'b1);
  endtask

  task automatic push_reads(input logic [AW-1:0] a, input int l);
    for (int i = 0; i <= l; i++) exp_rd.push_back('{ref_mem[AW'(a + i)], i == l, i == 0});
  endtask

  task automatic read_burst(input logic [AW-1:0] a, input int l, input bit spam);
    push_reads(a, l);
    issue(1'b0, a, l);
    wait_idle(spam);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit found, hs, pco;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = '0;
      ref_mem[i] = '0;
    end

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_controls", 32'({chip_select, write_enable, output_enable}), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_rd_last", 32'(rd_last), 0);
    chk("rst_addr", 32'(addr), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    rd_ready = 1'b1;
    tie_mode = 1'b1;

    // Single write then single read, with read latency
    wq = '{16'hA5C3};
    wr_log.delete();
    write_burst(16'h0010, 0, 0);
    chk("t1_write_count", 32'(wr_log.size()), 1);
    if (wr_log.size() == 1) chk("t1_write_addr", 32'(wr_log[0]), 32'h0010);
    got_rd.delete(); got_last.delete();
    push_reads(16'h0010, 0);
    issue(1'b0, 16'h0010, 0);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rd_valid) begin
        lat = k;
        break;
      end
    end
    chk("t1_rd_latency", 32'(lat), 3);
    wait_idle(1'b1);
    chk("t1_read_count", 32'(got_rd.size()), 1);
    if (got_rd.size() == 1) begin
      chk("t1_read_data", 32'(got_rd[0]), 32'hA5C3);
      chk("t1_read_last", 32'(got_last[0]), 1);
    end

    // Burst across the bank boundary with write gaps, readback at full rate
    wq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    wr_log.delete();
    write_burst(16'h3FFE, 3, 2);
    chk("t2_write_count", 32'(wr_log.size()), 4);
    if (wr_log.size() == 4) begin
      chk("t2_addr0", 32'(wr_log[0]), 32'h3FFE);
      chk("t2_addr1", 32'(wr_log[1]), 32'h3FFF);
      chk("t2_addr2", 32'(wr_log[2]), 32'h4000);
      chk("t2_addr3", 32'(wr_log[3]), 32'h4001);
    end
    got_rd.delete(); got_last.delete();
    read_burst(16'h3FFE, 3, 1'b1);
    chk("t2_read_count", 32'(got_rd.size()), 4);
    if (got_rd.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t2_read_data", 32'(got_rd[i]), 32'(16'h1111 * (i + 1)));
        chk("t2_read_last", 32'(got_last[i]), 32'(i == 3));
      end
    end

    // Address wrap at the top of the space
    wq = '{16'hBEEF, 16'hCAFE};
    wr_log.delete();
    write_burst(16'hFFFF, 1, 0);
    chk("t3_write_count", 32'(wr_log.size()), 2);
    if (wr_log.size() == 2) chk("t3_wrap_addr", 32'(wr_log[1]), 32'h0000);
    got_rd.delete(); got_last.delete();
    read_burst(16'h0000, 0, 1'b0);
    if (got_rd.size() == 1) chk("t3_read_data", 32'(got_rd[0]), 32'hCAFE);
    else chk("t3_read_count", 32'(got_rd.size()), 1);

    // Consumer backpressure for five cycles on the first of two beats
    tie_mode = 1'b0;
    @(posedge clk);
    #1 rd_ready = 1'b0;
    got_rd.delete(); got_last.delete();
    push_reads(16'h3FFE, 1);
    issue(1'b0, 16'h3FFE, 1);
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rd_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("t4_rd_valid_seen", 32'(found), 1);
    repeat (5) @(posedge clk);
    #1 rd_ready = 1'b1;
    wait_idle(1'b0);
    chk("t4_read_count", 32'(got_rd.size()), 2);
    if (got_rd.size() == 2) begin
      chk("t4_beat0", 32'(got_rd[0]), 32'h1111);
      chk("t4_beat1", 32'(got_rd[1]), 32'h2222);
    end

    // Reset pulsed during the capture cycle of beat two of a four-beat read
    tie_mode = 1'b1;
    push_reads(16'h3FFE, 3);
    issue(1'b0, 16'h3FFE, 3);
    found = 1'b0; hs = 1'b0; pco = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rd_valid && rd_ready) hs = 1'b1;
      else if (hs && chip_select && output_enable && pco) begin
        found = 1'b1;
        break;
      end
      pco = chip_select && output_enable;
    end
    chk("t5_found_capture", 32'(found), 1);
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_rd.delete();
    @(negedge clk);
    chk("t5_controls", 32'({chip_select, write_enable, output_enable}), 0);
    chk("t5_rd_valid", 32'(rd_valid), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_req_ready", 32'(req_ready), 1);
    chk("t5_addr", 32'(addr), 0);
    wq = '{16'h5A5A};
    write_burst(16'h0200, 0, 1);
    got_rd.delete(); got_last.delete();
    read_burst(16'h0200, 0, 1'b0);
    if (got_rd.size() == 1) chk("t5_read_after_reset", 32'(got_rd[0]), 32'h5A5A);
    else chk("t5_read_count", 32'(got_rd.size()), 1);

    // Randomized traffic with random backpressure
    tie_mode = 1'b0;
    rd_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [AW-1:0] a;
      int l;
      case ($urandom_range(0, 2))
        0: a = AW'(16'h0100 + $urandom_range(0, 15));
        1: a = AW'(16'hFFFC + $urandom_range(0, 7));
        default: a = AW'($urandom);
      endcase
      l = int'($urandom_range(0, 5));
      if ($urandom_range(0, 1) == 1) write_burst(a, l, -1);
      else read_burst(a, l, 1'($urandom));
    end
    rd_rand = 1'b0;
    @(posedge clk);
    #1 rd_ready = 1'b1;
    repeat (3) @(negedge clk);

    chk("end_writes_drained", 32'(exp_wr.size()), 0);
    chk("end_reads_drained", 32'(exp_rd.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
